// File: rtl/mips_program_loader.sv
// mips_program_loader: boot-time writer for the MIPS instruction memory.
// Takes a length-prefixed, little-endian byte image over a valid/ready
// port. It packs the bytes into 32-bit words, strobes each word into
// program memory, and keeps the CPU in reset until the whole image has landed.
// Optional: define LOADER_CHECKSUM_EN to require a trailing mod-256 sum byte.
module mips_program_loader #(
    parameter int          MEMORY_DEPTH = 32,
    parameter logic [31:0] BASE_ADDRESS = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [7:0]  ByteIn,
    input  logic        ByteValid,
    output logic        ByteReady,
    output logic        MemWrite,
    output logic [31:0] MemAddress,
    output logic [31:0] MemData,
    output logic        CpuResetN,
    output logic        Busy,
    output logic        Done,
    output logic        Error,
    output logic [15:0] WordCount
);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CHK, S_DONE, S_ERR
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_DONE, S_ERR
    } state_t;
`endif

    state_t      state, next_state;
    logic        accept;
    logic [1:0]  byte_index;
    logic [15:0] word_index;
    logic [23:0] word_buf;     // lanes 0..2 of the word being assembled
    logic [15:0] len_field;
    logic        last_word;
    logic        start_load;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  chk_sum;
`endif

    assign accept     = ByteValid & ByteReady;
    assign len_field  = {ByteIn, WordCount[7:0]};
    assign last_word  = ((word_index + 16'd1) == WordCount);
    assign start_load = (next_state == S_LEN_LO) && (state != S_LEN_LO);

    // State register
    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= next_state;
    end

    // Next-state logic: header parse, length check, word counting
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: if (Start) next_state = S_LEN_LO;
            S_LEN_LO: if (accept) next_state = S_LEN_HI;
            S_LEN_HI: if (accept) begin
                if (len_field == 16'd0)
`ifdef LOADER_CHECKSUM_EN
                    next_state = S_CHK;
`else
                    next_state = S_DONE;
`endif
                else if (len_field > 16'(MEMORY_DEPTH))
                    next_state = S_ERR;
                else
                    next_state = S_DATA;
            end
            S_DATA: if (accept && byte_index == 2'd3 && last_word)
`ifdef LOADER_CHECKSUM_EN
                next_state = S_CHK;
`else
                next_state = S_DONE;
`endif
`ifdef LOADER_CHECKSUM_EN
            S_CHK: if (accept) next_state = (ByteIn == chk_sum) ? S_DONE : S_ERR;
`endif
            default: next_state = S_IDLE;
        endcase
    end

    // Output decode: handshake and status flags purely from state
    always_comb begin
        ByteReady = 1'b0;
        Busy      = 1'b0;
        Done      = 1'b0;
        Error     = 1'b0;
        case (state)
            S_LEN_LO, S_LEN_HI, S_DATA: begin
                ByteReady = 1'b1;
                Busy      = 1'b1;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                ByteReady = 1'b1;
                Busy      = 1'b1;
            end
`endif
            S_DONE:  Done  = 1'b1;
            S_ERR:   Error = 1'b1;
            default: ;
        endcase
    end

    // Datapath: length capture, word assembly, write strobe, CPU reset release
    always_ff @(posedge clk) begin
        if (!reset) begin
            MemWrite   <= 1'b0;
            MemAddress <= '0;
            MemData    <= '0;
            CpuResetN  <= 1'b0;
            WordCount  <= '0;
            byte_index <= '0;
            word_index <= '0;
            word_buf   <= '0;
`ifdef LOADER_CHECKSUM_EN
            chk_sum    <= '0;
`endif
        end else begin
            MemWrite <= 1'b0;
            // Released only after a full cycle in DONE, so the last write has
            // committed; drops together with Done when a new load starts.
            CpuResetN <= (state == S_DONE) && (next_state == S_DONE);
            if (start_load) begin
                byte_index <= '0;
                word_index <= '0;
                WordCount  <= '0;
`ifdef LOADER_CHECKSUM_EN
                chk_sum    <= '0;
`endif
            end
            if (accept) begin
                case (state)
                    S_LEN_LO: WordCount[7:0]  <= ByteIn;
                    S_LEN_HI: WordCount[15:8] <= ByteIn;
                    S_DATA: begin
`ifdef LOADER_CHECKSUM_EN
                        chk_sum <= chk_sum + ByteIn;
`endif
                        byte_index <= byte_index + 2'd1;
                        case (byte_index)
                            2'd0: word_buf[7:0]   <= ByteIn;
                            2'd1: word_buf[15:8]  <= ByteIn;
                            2'd2: word_buf[23:16] <= ByteIn;
                            default: begin
                                // Output registers load only here, so they
                                // hold steady while the next word assembles.
                                MemWrite   <= 1'b1;
                                MemData    <= {ByteIn, word_buf};
                                MemAddress <= BASE_ADDRESS + {14'd0, word_index, 2'b00};
                                word_index <= word_index + 16'd1;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mips_program_loader.sv
// Bench for mips_program_loader: directed table, abort/reset sequences and
// randomized images checked against a byte-array reference model.
module tb_mips_program_loader;
    localparam int          DEPTH = 32;
    localparam logic [31:0] BASE  = 32'h0040_0000;

    logic        clk, reset, Start, ByteValid;
    logic [7:0]  ByteIn;
    logic        ByteReady, MemWrite, CpuResetN, Busy, Done, Error;
    logic [31:0] MemAddress, MemData;
    logic [15:0] WordCount;

    mips_program_loader #(.MEMORY_DEPTH(DEPTH), .BASE_ADDRESS(BASE)) dut (
        .clk(clk), .reset(reset), .Start(Start), .ByteIn(ByteIn),
        .ByteValid(ByteValid), .ByteReady(ByteReady), .MemWrite(MemWrite),
        .MemAddress(MemAddress), .MemData(MemData), .CpuResetN(CpuResetN),
        .Busy(Busy), .Done(Done), .Error(Error), .WordCount(WordCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [31:0] wr_addr_q[$], wr_data_q[$];
    logic [31:0] exp_addr_q[$], exp_data_q[$];

    // Capture every write strobe
    always @(negedge clk) begin
        if (MemWrite) begin
            wr_addr_q.push_back(MemAddress);
            wr_data_q.push_back(MemData);
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, ".ByteReady"}, 32'(ByteReady), 0);
        chk({name, ".MemWrite"},  32'(MemWrite), 0);
        chk({name, ".MemAddress"}, MemAddress, 0);
        chk({name, ".MemData"},   MemData, 0);
        chk({name, ".CpuResetN"}, 32'(CpuResetN), 0);
        chk({name, ".Busy"},      32'(Busy), 0);
        chk({name, ".Done"},      32'(Done), 0);
        chk({name, ".Error"},     32'(Error), 0);
        chk({name, ".WordCount"}, 32'(WordCount), 0);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic send_byte(input logic [7:0] b, input int gap, input logic st);
        int n;
        Start = st;
        ByteValid = 1'b0;
        repeat (gap) @(negedge clk);
        ByteIn = b;
        ByteValid = 1'b1;
        n = 0;
        while (!ByteReady && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ByteReady) begin
            tests++;
            fails++;
            $display("FAIL byte_timeout: ByteReady stuck at 0, required 1");
        end
        @(negedge clk);
        ByteValid = 1'b0;
    endtask

    // Reference: decode the image from the format rules alone
    task automatic model(input logic [7:0] img[$], output bit e_done, output bit e_err,
                         output logic [15:0] e_wc);
        int len;
        len = int'({img[1], img[0]});
        e_wc = 16'(len);
        exp_addr_q.delete();
        exp_data_q.delete();
        if (len > DEPTH) begin
            e_done = 0; e_err = 1;
        end else begin
            for (int w = 0; w < len; w++) begin
                exp_addr_q.push_back(BASE + 32'(4 * w));
                exp_data_q.push_back({img[2+4*w+3], img[2+4*w+2], img[2+4*w+1], img[2+4*w]});
            end
`ifdef LOADER_CHECKSUM_EN
            begin
                int s;
                s = 0;
                for (int i = 0; i < 4 * len; i++) s = (s + int'(img[2+i])) % 256;
                e_done = (img.size() > 2 + 4 * len) && (int'(img[2+4*len]) == s);
                e_err = !e_done;
            end
`else
            e_done = 1; e_err = 0;
`endif
        end
    endtask

    task automatic run_image(input string name, input logic [7:0] img_in[$], input int gap,
                             input bit hold_start, input bit add_chk);
        logic [7:0] img[$];
        bit e_done, e_err;
        logic [15:0] e_wc;
        int n;
        img = img_in;
`ifdef LOADER_CHECKSUM_EN
        if (add_chk && int'({img[1], img[0]}) <= DEPTH) begin
            int s;
            s = 0;
            for (int i = 2; i < img.size(); i++) s = (s + int'(img[i])) % 256;
            img.push_back(8'(s));
        end
`endif
        model(img, e_done, e_err, e_wc);
        wr_addr_q.delete();
        wr_data_q.delete();
        Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        chk({name, ".busy_after_start"}, 32'(Busy), 1);
        chk({name, ".cpu_held"}, 32'(CpuResetN), 0);
        for (int i = 0; i < img.size(); i++)
            send_byte(img[i], (i == 0) ? 0 : gap, hold_start && (i < img.size() - 1));
        Start = 1'b0;
        chk({name, ".done"}, 32'(Done), 32'(e_done));
        chk({name, ".error"}, 32'(Error), 32'(e_err));
        chk({name, ".busy_end"}, 32'(Busy), 0);
        chk({name, ".ready_end"}, 32'(ByteReady), 0);
        chk({name, ".cpu_reset_first"}, 32'(CpuResetN), 0);
        @(negedge clk);
        chk({name, ".cpu_reset_next"}, 32'(CpuResetN), 32'(e_done));
        repeat (2) @(negedge clk);
        chk({name, ".word_count"}, 32'(WordCount), 32'(e_wc));
        chk({name, ".num_writes"}, 32'(wr_addr_q.size()), 32'(exp_addr_q.size()));
        n = (wr_addr_q.size() < exp_addr_q.size()) ? wr_addr_q.size() : exp_addr_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s.addr%0d", name, i), wr_addr_q[i], exp_addr_q[i]);
            chk($sformatf("%s.data%0d", name, i), wr_data_q[i], exp_data_q[i]);
        end
    endtask

    typedef struct {
        string       name;
        logic [7:0]  img[12];
        int          n;
        int          gap;
        bit          hold;
        bit          exp_done;
        bit          exp_err;
        int          exp_nwr;
        logic [31:0] exp_first_data;
        logic [31:0] exp_last_addr;
        logic [15:0] exp_wc;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [7:0] q[$];

        vecs[0] = '{"two_word", '{8'h02,8'h00,8'h13,8'h00,8'h08,8'h20,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
                    10, 0, 0, 1, 0, 2, 32'h2008_0013, 32'h0040_0004, 16'd2};
        vecs[1] = '{"zero_len", '{8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
                    2, 0, 0, 1, 0, 0, 32'h0, 32'h0, 16'd0};
        vecs[2] = '{"oversize", '{8'h21,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
                    2, 0, 0, 0, 1, 0, 32'h0, 32'h0, 16'd33};
        vecs[3] = '{"stall", '{8'h02,8'h00,8'h13,8'h00,8'h08,8'h20,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
                    10, 3, 0, 1, 0, 2, 32'h2008_0013, 32'h0040_0004, 16'd2};
        vecs[4] = '{"start_held", '{8'h02,8'h00,8'h13,8'h00,8'h08,8'h20,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
                    10, 1, 1, 1, 0, 2, 32'h2008_0013, 32'h0040_0004, 16'd2};
        vecs[5] = '{"one_word", '{8'h01,8'h00,8'h01,8'h02,8'h03,8'h04,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
                    6, 0, 0, 1, 0, 1, 32'h0403_0201, 32'h0040_0000, 16'd1};

        // Reset state, with a byte offered throughout
        reset = 1'b0; Start = 1'b0; ByteValid = 1'b1; ByteIn = 8'hFF;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b1;
        @(negedge clk);
        chk("idle_ready", 32'(ByteReady), 0);
        ByteValid = 1'b0;

        // Directed table
        foreach (vecs[k]) begin
            q.delete();
            for (int i = 0; i < vecs[k].n; i++) q.push_back(vecs[k].img[i]);
            run_image(vecs[k].name, q, vecs[k].gap, vecs[k].hold, 1);
            chk({vecs[k].name, ".tbl_done"}, 32'(Done), 32'(vecs[k].exp_done));
            chk({vecs[k].name, ".tbl_err"}, 32'(Error), 32'(vecs[k].exp_err));
            chk({vecs[k].name, ".tbl_nwr"}, 32'(wr_data_q.size()), 32'(vecs[k].exp_nwr));
            chk({vecs[k].name, ".tbl_wc"}, 32'(WordCount), 32'(vecs[k].exp_wc));
            if (vecs[k].exp_nwr > 0 && wr_data_q.size() > 0) begin
                chk({vecs[k].name, ".tbl_first_data"}, wr_data_q[0], vecs[k].exp_first_data);
                chk({vecs[k].name, ".tbl_first_addr"}, wr_addr_q[0], BASE);
                chk({vecs[k].name, ".tbl_last_addr"}, wr_addr_q[$], vecs[k].exp_last_addr);
            end
        end

`ifdef LOADER_CHECKSUM_EN
        q = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
        run_image("chk_good", q, 0, 0, 0);
        chk("chk_good.done", 32'(Done), 1);
        q = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0B};
        run_image("chk_bad", q, 0, 0, 0);
        chk("chk_bad.error", 32'(Error), 1);
        chk("chk_bad.nwr", 32'(wr_data_q.size()), 1);
        if (wr_data_q.size() > 0) chk("chk_bad.data", wr_data_q[0], 32'h0403_0201);
`endif

        // Abort mid-load after the 5th data byte
        wr_data_q.delete();
        wr_addr_q.delete();
        Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h08, 8'h20, 8'h08};
        foreach (q[i]) send_byte(q[i], 0, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        chk_all_zero("abort");
        chk("abort.nwr", 32'(wr_data_q.size()), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort.idle_busy", 32'(Busy), 0);

        // Randomized images, including the 32/33-word boundary
        for (int k = 0; k < 24; k++) begin
            int len;
            bit bad;
            len = (k == 0) ? DEPTH : (k == 1) ? DEPTH + 1 : int'($urandom_range(0, DEPTH + 2));
            bad = (k > 1) && ($urandom_range(0, 3) == 0);
            q.delete();
            q.push_back(8'(len));
            q.push_back(8'(len >> 8));
            if (len <= DEPTH)
                for (int i = 0; i < 4 * len; i++) q.push_back(8'($urandom));
`ifdef LOADER_CHECKSUM_EN
            if (bad && len <= DEPTH) begin
                int s;
                s = 1;
                for (int i = 2; i < q.size(); i++) s = (s + int'(q[i])) % 256;
                q.push_back(8'(s));
            end
`endif
            run_image($sformatf("rand%0d", k), q, int'($urandom_range(0, 2)), 0, !bad);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
